// File: rtl/set_field_stage.sv
// rtl/set_field_stage.sv - two-stage MAC rewrite / TTL decrement action stage with field-write helper
//
// set_field_async overwrites one slice of a header vector combinationally.
// set_field_stage registers the beat in S1 and precomputes the TTL-derived words.
// S2 chains four field writers, computes the incremental checksum, and drives the output register.

module set_field_async #(
  parameter int DATA_WIDTH  = 600,
  parameter int FIELD_WIDTH = 8,
  parameter int OFFSET      = 0
) (
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic [FIELD_WIDTH-1:0] field,
  input  logic                   en,
  output logic [DATA_WIDTH-1:0]  data_out
);

  // overwrite the slice when enabled, pass everything else through untouched
  always_comb begin
    data_out = data_in;
    if (en) begin
      data_out[OFFSET +: FIELD_WIDTH] = field;
    end
  end

endmodule

module set_field_stage #(
  parameter int DATA_WIDTH  = 600,
  parameter int DMAC_OFFSET = 0,
  parameter int SMAC_OFFSET = 48,
  parameter int TTL_OFFSET  = 176,
  parameter int CSUM_OFFSET = 192
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_hdr_data,
  input  logic [2:0]            s_hdr_action,
  input  logic [47:0]           s_hdr_dmac,
  input  logic [47:0]           s_hdr_smac,
  input  logic                  s_hdr_valid,
  output logic                  s_hdr_ready,
  output logic [DATA_WIDTH-1:0] m_hdr_data,
  output logic                  m_hdr_drop,
  output logic                  m_hdr_valid,
  input  logic                  m_hdr_ready,
  output logic [31:0]           stat_pkt_cnt,
  output logic [31:0]           stat_drop_cnt
);

  if (DATA_WIDTH < 208) begin : g_width_check
    $error("set_field_stage: DATA_WIDTH must be at least 208");
  end

  // ones'-complement 16-bit add, end-around carry folded twice
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    s = {1'b0, s[15:0]} + {16'b0, s[16]};
    s = {1'b0, s[15:0]} + {16'b0, s[16]};
    return s[15:0];
  endfunction

  // S1 state
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [2:0]            s1_action;
  logic [47:0]           s1_dmac;
  logic [47:0]           s1_smac;
  logic                  s1_expire;
  logic [15:0]           s1_m;
  logic [15:0]           s1_mp;

  logic s1_adv;
  logic s2_adv;

  // TTL/protocol view of the incoming beat
  logic [7:0]  in_ttl;
  logic [7:0]  in_proto;
  logic [15:0] in_m;

  assign in_ttl   = s_hdr_data[TTL_OFFSET +: 8];
  assign in_proto = s_hdr_data[TTL_OFFSET+8 +: 8];
  assign in_m     = {in_ttl, in_proto};

  assign s2_adv      = !m_hdr_valid | m_hdr_ready;
  assign s1_adv      = !s1_valid | s2_adv;
  assign s_hdr_ready = s1_adv;

  // S1 register: capture the beat and the TTL words used by the checksum update
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= s_hdr_valid;
      if (s_hdr_valid) begin
        s1_data   <= s_hdr_data;
        s1_action <= s_hdr_action;
        s1_dmac   <= s_hdr_dmac;
        s1_smac   <= s_hdr_smac;
        s1_expire <= s_hdr_action[2] & (in_ttl <= 8'd1);
        s1_m      <= in_m;
        s1_mp     <= in_m - 16'h0100;
      end
    end
  end

  // S2 combinational rewrite
  logic                  do_ttl;
  logic [7:0]            ttl_new;
  logic [15:0]           csum_old;
  logic [15:0]           csum_new;
  logic [DATA_WIDTH-1:0] w_dmac;
  logic [DATA_WIDTH-1:0] w_smac;
  logic [DATA_WIDTH-1:0] w_ttl;
  logic [DATA_WIDTH-1:0] w_csum;

  assign do_ttl   = s1_action[2] & ~s1_expire;
  assign ttl_new  = s1_m[15:8] - 8'd1;
  assign csum_old = s1_data[CSUM_OFFSET +: 16];
  assign csum_new = ~oc_add(oc_add(~csum_old, ~s1_m), s1_mp);

  set_field_async #(.DATA_WIDTH(DATA_WIDTH), .FIELD_WIDTH(48), .OFFSET(DMAC_OFFSET)) u_set_dmac (
    .data_in  (s1_data),
    .field    (s1_dmac),
    .en       (s1_action[0]),
    .data_out (w_dmac)
  );

  set_field_async #(.DATA_WIDTH(DATA_WIDTH), .FIELD_WIDTH(48), .OFFSET(SMAC_OFFSET)) u_set_smac (
    .data_in  (w_dmac),
    .field    (s1_smac),
    .en       (s1_action[1]),
    .data_out (w_smac)
  );

  set_field_async #(.DATA_WIDTH(DATA_WIDTH), .FIELD_WIDTH(8), .OFFSET(TTL_OFFSET)) u_set_ttl (
    .data_in  (w_smac),
    .field    (ttl_new),
    .en       (do_ttl),
    .data_out (w_ttl)
  );

  set_field_async #(.DATA_WIDTH(DATA_WIDTH), .FIELD_WIDTH(16), .OFFSET(CSUM_OFFSET)) u_set_csum (
    .data_in  (w_ttl),
    .field    (csum_new),
    .en       (do_ttl),
    .data_out (w_csum)
  );

  // S2 register: hold while stalled, load the rewritten header when advancing
  always_ff @(posedge clk) begin
    if (rst) begin
      m_hdr_valid <= 1'b0;
      m_hdr_data  <= '0;
      m_hdr_drop  <= 1'b0;
    end else if (s2_adv) begin
      m_hdr_valid <= s1_valid;
      if (s1_valid) begin
        m_hdr_data <= w_csum;
        m_hdr_drop <= s1_expire;
      end
    end
  end

  // statistics: count every output handshake, and those carrying drop
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkt_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else if (m_hdr_valid & m_hdr_ready) begin
      stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      if (m_hdr_drop) begin
        stat_drop_cnt <= stat_drop_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_set_field_stage.sv
// tb/tb_set_field_stage.sv - scoreboard bench for set_field_stage
module tb_set_field_stage;

  localparam int DW = 600;

  typedef struct {
    logic [DW-1:0] data;
    logic          drop;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_hdr_data;
  logic [2:0]    s_hdr_action;
  logic [47:0]   s_hdr_dmac;
  logic [47:0]   s_hdr_smac;
  logic          s_hdr_valid;
  logic          s_hdr_ready;
  logic [DW-1:0] m_hdr_data;
  logic          m_hdr_drop;
  logic          m_hdr_valid;
  logic          m_hdr_ready;
  logic [31:0]   stat_pkt_cnt;
  logic [31:0]   stat_drop_cnt;

  int checks   = 0;
  int failures = 0;

  exp_t          sbq[$];
  int            inflight = 0;
  logic [31:0]   mpkt = 0;
  logic [31:0]   mdrop = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_drop;
  logic [DW-1:0] last_data;
  logic          last_drop;
  int            rdy_mode = 0;

  set_field_stage dut (
    .clk           (clk),
    .rst           (rst),
    .s_hdr_data    (s_hdr_data),
    .s_hdr_action  (s_hdr_action),
    .s_hdr_dmac    (s_hdr_dmac),
    .s_hdr_smac    (s_hdr_smac),
    .s_hdr_valid   (s_hdr_valid),
    .s_hdr_ready   (s_hdr_ready),
    .m_hdr_data    (m_hdr_data),
    .m_hdr_drop    (m_hdr_drop),
    .m_hdr_valid   (m_hdr_valid),
    .m_hdr_ready   (m_hdr_ready),
    .stat_pkt_cnt  (stat_pkt_cnt),
    .stat_drop_cnt (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic chk_hdr(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // reference: header rules with plain integer ones'-complement arithmetic
  function automatic exp_t model(input logic [DW-1:0] d, input logic [2:0] a,
                                 input logic [47:0] dm, input logic [47:0] sm);
    exp_t        e;
    logic [31:0] ttl, proto, hc, m, mp, s;
    e.data = d;
    ttl    = {24'b0, d[176 +: 8]};
    proto  = {24'b0, d[184 +: 8]};
    hc     = {16'b0, d[192 +: 16]};
    e.drop = a[2] && (ttl <= 1);
    if (a[0]) e.data[0 +: 48] = dm;
    if (a[1]) e.data[48 +: 48] = sm;
    if (a[2] && !e.drop) begin
      m  = ttl * 256 + proto;
      mp = m - 256;
      s  = (hc ^ 32'hFFFF) + (m ^ 32'hFFFF) + mp;
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
      e.data[176 +: 8]  = 8'(ttl - 1);
      e.data[192 +: 16] = 16'(s ^ 32'hFFFF);
    end
    return e;
  endfunction

  task automatic rand_hdr(output logic [DW-1:0] h);
    logic [607:0] t;
    for (int i = 0; i < 19; i++) t[i*32 +: 32] = $urandom();
    h = t[DW-1:0];
  endtask

  // drive one beat, push its expectation when the handshake is seen
  task automatic send(input logic [DW-1:0] d, input logic [2:0] a,
                      input logic [47:0] dm, input logic [47:0] sm);
    bit ok = 0;
    s_hdr_data   = d;
    s_hdr_action = a;
    s_hdr_dmac   = dm;
    s_hdr_smac   = sm;
    s_hdr_valid  = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_hdr_ready) begin
        sbq.push_back(model(d, a, dm, sm));
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=stalled expected=accept");
    end
    @(posedge clk);
    #1;
    s_hdr_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      if (sbq.size() == 0) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout got=%0d expected=0 pending", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // downstream ready pattern: 0 always ready, 1 random, 2 never ready
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_hdr_ready = 1'($urandom_range(0, 1));
      2:       m_hdr_ready = 1'b0;
      default: m_hdr_ready = 1'b1;
    endcase
  end

  // monitor: ready rule, stall stability, in-order scoreboard, counters
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sbq.delete();
      inflight   = 0;
      mpkt       = 0;
      mdrop      = 0;
      prev_stall = 1'b0;
    end else begin
      chk32("s_hdr_ready", {31'b0, s_hdr_ready}, {31'b0, !(inflight == 2 && !m_hdr_ready)});
      if (prev_stall) begin
        chk32("stall_valid", {31'b0, m_hdr_valid}, 32'd1);
        chk_hdr("stall_data", m_hdr_data, prev_data);
        chk32("stall_drop", {31'b0, m_hdr_drop}, {31'b0, prev_drop});
      end
      if (m_hdr_valid && m_hdr_ready) begin
        chk32("stat_pkt_cnt", stat_pkt_cnt, mpkt);
        chk32("stat_drop_cnt", stat_drop_cnt, mdrop);
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat got=%h expected=none", m_hdr_data);
        end else begin
          e = sbq.pop_front();
          chk_hdr("out_data", m_hdr_data, e.data);
          chk32("out_drop", {31'b0, m_hdr_drop}, {31'b0, e.drop});
          mpkt = mpkt + 1;
          if (e.drop) mdrop = mdrop + 1;
        end
        last_data = m_hdr_data;
        last_drop = m_hdr_drop;
      end
      inflight = inflight + ((s_hdr_valid && s_hdr_ready) ? 1 : 0)
                          - ((m_hdr_valid && m_hdr_ready) ? 1 : 0);
      prev_stall = m_hdr_valid && !m_hdr_ready;
      prev_data  = m_hdr_data;
      prev_drop  = m_hdr_drop;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] h;
    logic [2:0]    a;
    rst          = 1'b1;
    s_hdr_valid  = 1'b0;
    s_hdr_data   = '0;
    s_hdr_action = '0;
    s_hdr_dmac   = '0;
    s_hdr_smac   = '0;
    m_hdr_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    chk32("rst_valid", {31'b0, m_hdr_valid}, 32'd0);
    chk_hdr("rst_data", m_hdr_data, '0);
    chk32("rst_drop", {31'b0, m_hdr_drop}, 32'd0);
    chk32("rst_pkt", stat_pkt_cnt, 32'd0);
    chk32("rst_dropcnt", stat_drop_cnt, 32'd0);
    chk32("rst_ready", {31'b0, s_hdr_ready}, 32'd1);

    // passthrough with two-cycle latency
    rand_hdr(h);
    send(h, 3'b000, 48'h0, 48'h0);
    chk32("lat_not_yet", {31'b0, m_hdr_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk32("lat_valid", {31'b0, m_hdr_valid}, 32'd1);
    chk_hdr("pass_data", m_hdr_data, h);
    drain();
    chk32("pass_pkt", stat_pkt_cnt, 32'd1);

    // full rewrite, fixed vector
    rand_hdr(h);
    h[176 +: 8]  = 8'd64;
    h[184 +: 8]  = 8'd6;
    h[192 +: 16] = 16'hB1E6;
    send(h, 3'b111, 48'h0A0B0C0D0E0F, 48'h112233445566);
    drain();
    chk32("fr_dmac_lo", last_data[31:0], 32'h0C0D0E0F);
    chk32("fr_smac_lo", last_data[79:48], 32'h33445566);
    chk32("fr_ttl", {24'b0, last_data[176 +: 8]}, 32'd63);
    chk32("fr_csum", {16'b0, last_data[192 +: 16]}, 32'h0000B2E6);
    chk32("fr_drop", {31'b0, last_drop}, 32'd0);

    // expiry: TTL 1 then 0
    do_reset();
    rand_hdr(h);
    h[176 +: 8] = 8'd1;
    send(h, 3'b100, 48'h0, 48'h0);
    h[176 +: 8] = 8'd0;
    send(h, 3'b101, 48'hDEADBEEF0001, 48'h0);
    drain();
    chk32("exp_ttl", {24'b0, last_data[176 +: 8]}, 32'd0);
    chk32("exp_csum", {16'b0, last_data[192 +: 16]}, {16'b0, h[192 +: 16]});
    chk32("exp_drop", {31'b0, last_drop}, 32'd1);
    chk32("exp_dropcnt", stat_drop_cnt, 32'd2);

    // backpressure: 10 back-to-back beats
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      rand_hdr(h);
      h[176 +: 8] = 8'($urandom_range(0, 255));
      send(h, 3'($urandom_range(0, 7)), {$urandom(), 16'($urandom())}, {$urandom(), 16'($urandom())});
    end
    drain();

    // randomized traffic, small TTLs favoured
    for (int i = 0; i < 60; i++) begin
      rand_hdr(h);
      if ($urandom_range(0, 1) == 1) h[176 +: 8] = 8'($urandom_range(0, 3));
      a = 3'($urandom_range(0, 7));
      send(h, a, {$urandom(), 16'($urandom())}, {$urandom(), 16'($urandom())});
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // reset mid-stream with both stages full
    rdy_mode = 2;
    rand_hdr(h);
    send(h, 3'b000, 48'h0, 48'h0);
    send(h, 3'b011, 48'h1, 48'h2);
    do_reset();
    chk32("mid_valid", {31'b0, m_hdr_valid}, 32'd0);
    chk32("mid_pkt", stat_pkt_cnt, 32'd0);
    chk32("mid_dropcnt", stat_drop_cnt, 32'd0);
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;

    // counter wrap
    dut.stat_pkt_cnt = 32'hFFFFFFFF;
    mpkt = 32'hFFFFFFFF;
    rand_hdr(h);
    send(h, 3'b000, 48'h0, 48'h0);
    drain();
    chk32("wrap_pkt", stat_pkt_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/set_field_stage.md
# set_field_stage

Registered two-stage action stage in the l3fwd action pipe: accepts a parsed header vector plus a per-packet action descriptor over a valid/ready handshake, and rewrites Ethernet destination/source MAC. It decrements the IPv4 TTL with an RFC 1624 incremental header-checksum update and flags TTL-expired packets for drop. It sits directly upstream of the packet deparser and instantiates `set_field_async` for each field write.

## Interface
- `DATA_WIDTH`, 600: header vector width. Must be ≥ 208; elaboration error otherwise.
- `DMAC_OFFSET`, 0: bit offset of the 48-bit destination MAC.
- `SMAC_OFFSET`, 48: bit offset of the 48-bit source MAC.
- `TTL_OFFSET`, 176: bit offset of the 8-bit IPv4 TTL. Bits [TTL_OFFSET+15:TTL_OFFSET+8] are the protocol byte.
- `CSUM_OFFSET`, 192: bit offset of the 16-bit IPv4 header checksum.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `s_hdr_data`  in  DATA_WIDTH  input header vector.
- `s_hdr_action`  in  3  action bits: [0] set_dmac, [1] set_smac, [2] dec_ttl.
- `s_hdr_dmac`  in  48  new destination MAC.
- `s_hdr_smac`  in  48  new source MAC.
- `s_hdr_valid`  in  1  input beat valid.
- `s_hdr_ready`  out  1  input accepted when high with valid.
- `m_hdr_data`  out  DATA_WIDTH  rewritten header.
- `m_hdr_drop`  out  1  TTL expired; downstream discards the packet.
- `m_hdr_valid`  out  1  output beat valid.
- `m_hdr_ready`  in  1  downstream accepts.
- `stat_pkt_cnt`  out  32  packets emitted.
- `stat_drop_cnt`  out  32  packets emitted with drop set.

## Operation
- Stage 1 (S1) registers data, action, and MACs on a handshake. It also computes:
  - `ttl_old`, the 8-bit TTL.
  - `expire = dec_ttl & (ttl_old ≤ 1)`.
  - `m = {ttl_old, proto}`.
  - `m' = m − 16'h0100`.
- Stage 2 (S2) registers the final header.
  - DMAC is replaced if set_dmac; SMAC is replaced if set_smac.
  - If dec_ttl and not expire: TTL ← ttl_old−1 and checksum ← HC'. HC' = ~(~HC +' ~m +' m'), where +' is a 16-bit ones'-complement add with end-around carry, folded twice.
  - If expire: TTL and checksum are unchanged and `m_hdr_drop`=1. MAC rewrites are still applied.
  - Action 3'b000: header passes bit-exact.
  - Fields outside the written slices are never modified.
- Field writes use `set_field_async` instances chained combinationally into the S2 register.
- Counters increment on each output handshake (`m_hdr_valid & m_hdr_ready`).
  - `stat_pkt_cnt` increments on every output handshake.
  - `stat_drop_cnt` increments additionally when `m_hdr_drop`=1.
  - Both are unsigned 32-bit and wrap from 0xFFFFFFFF to 0.

## Timing
- Latency: 2 cycles from input handshake to `m_hdr_valid` with no backpressure. Full throughput is one beat per cycle.
- Ready chain, combinational:
  - `s2_adv = !s2_valid | m_hdr_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
  - `s_hdr_ready = s1_adv`.
- While `m_hdr_valid` is high and ready is low, `m_hdr_data`, `m_hdr_drop`, and `m_hdr_valid` hold stable. No beat is lost or duplicated.
- Simultaneous input and output handshakes with both stages full: all stages shift and the occupancy stays 2.
- Reset, including mid-stream, at the next `clk` edge with `rst`=1:
  - S1/S2 valids are cleared and in-flight beats discarded.
  - `m_hdr_valid`=0, `m_hdr_data`=0, `m_hdr_drop`=0.
  - Both counters = 0.
  - `s_hdr_ready`=1 in the cycle after reset deasserts; it is a don't-care during reset, and no beat is accepted while `rst`=1.
- Data registers are don't-care when their valid is 0, except `m_hdr_data`, which is reset to 0.

## Test plan
- Passthrough:
  - Stimulus: action 000, random header, `m_hdr_ready`=1.
  - Required: identical header 2 cycles later, drop=0, `stat_pkt_cnt`=1.
- Full rewrite:
  - Stimulus: action 111, dmac=0x0A0B0C0D0E0F, smac=0x112233445566, TTL=64, proto=6, checksum=0xB1E6.
  - Required: MACs replaced, TTL=63, checksum=0xB2E6, drop=0.
- Expiry:
  - Stimulus: dec_ttl with TTL=1, then TTL=0.
  - Required: both beats emitted with drop=1, TTL/checksum unchanged, `stat_drop_cnt`=2.
- Backpressure:
  - Stimulus: 10 back-to-back beats with a random `m_hdr_ready` pattern (~50% duty).
  - Required: output equals the expected sequence in order, `s_hdr_ready` low only when both stages are full, data stable while stalled.
- Reset mid-stream:
  - Stimulus: assert `rst` for one cycle with both stages valid.
  - Required: `m_hdr_valid`=0 and counters=0 the next cycle, no stale beat emitted afterward.
- Counter wrap:
  - Stimulus: force `stat_pkt_cnt` to 0xFFFFFFFF via hierarchical deposit, then one handshake.
  - Required: `stat_pkt_cnt`=0.
